mio_bridge: RTL and testbench

- Multi-slave memory/IO bridge between the multi-cycle CPU's memory port and up to N_SLAVES peripherals (RAM, GPIO, counters, display).
- Decodes the CPU address to one slave and applies that slave's fixed wait states.
- Waits for the slave's acknowledge, then returns read data together with a single-cycle MIO_ready pulse.
- Replaces the single-slave, always-ready memory path. Adds per-slave wait states, decode-miss error reporting and an optional access timeout.

---
 rtl/mio_bridge_if.sv | 28 ++
 rtl/mio_bridge.sv | 128 ++++++++++++
 tb/tb_mio_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mio_bridge_if.sv
// mio_bridge_if: CPU memory port and multi-slave bus seen by the memory/IO bridge.
interface mio_bridge_if #(
    parameter int N_SLAVES = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
);
    logic                         cpu_req;
    logic                         cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         mio_ready;
    logic                         err;
    logic [N_SLAVES-1:0]          s_sel;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;
    logic [N_SLAVES-1:0]          s_ack;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ack,
        output cpu_rdata, mio_ready, err, s_sel, s_we, s_addr, s_wdata
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ack,
        input  cpu_rdata, mio_ready, err, s_sel, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/mio_bridge.sv
// mio_bridge: decodes CPU accesses to N_SLAVES peripherals with per-slave wait states and ack.
// Optional access timeout is built when MIO_TIMEOUT_EN is defined.
module mio_bridge #(
    parameter int                    N_SLAVES    = 4,
    parameter int                    DATA_W      = 32,
    parameter int                    ADDR_W      = 32,
    parameter int                    SEL_HI      = 31,
    parameter int                    SEL_LO      = 28,
    parameter logic [4*N_SLAVES-1:0] WAIT_CYCLES = '0,
    parameter int                    TIMEOUT     = 255
) (
    input logic          clk,
    input logic          reset,
    mio_bridge_if.master bus
);
    localparam int SW = SEL_HI - SEL_LO + 1;
    localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          wait_q, wait_d;
    logic [SW-1:0]       sel_idx;
    logic                hit;
    assign sel_idx = bus.cpu_addr[SEL_HI:SEL_LO];
    assign hit     = int'(sel_idx) < N_SLAVES;
`ifdef MIO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT != 0;
`endif
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
`ifdef MIO_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: if (bus.cpu_req) begin
                addr_d  = bus.cpu_addr;
                wdata_d = bus.cpu_wdata;
                we_d    = bus.cpu_we;
                idx_d   = IW'(sel_idx);
                err_d   = !hit;
                sel_d   = hit ? N_SLAVES'(1) << IW'(sel_idx) : '0;
                wait_d  = hit ? WAIT_CYCLES[4*IW'(sel_idx) +: 4] : 4'd0;
                rdata_d = hit ? rdata_q : '0;
                state_d = hit ? ACCESS : DONE;
`ifdef MIO_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (bus.s_ack[idx_q]) begin
                    rdata_d = we_q ? rdata_q : bus.s_rdata[DATA_W*idx_q +: DATA_W];
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end
`ifdef MIO_TIMEOUT_EN
                to_d = to_q + 1'b1;
                // Completion in the same cycle as the limit wins over the timeout.
                if (state_d == ACCESS && to_q == TO_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wait_q  <= 4'd0;
`ifdef MIO_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
`ifdef MIO_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end
    assign bus.cpu_rdata = rdata_q;
    assign bus.mio_ready = state_q == DONE;
    assign bus.err       = err_q;
    assign bus.s_sel     = sel_q;
    assign bus.s_we      = we_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
endmodule

// File: tb/tb_mio_bridge.sv
// tb_mio_bridge: directed checks of decode, wait states, ack stalls, decode miss and async reset.
module tb_mio_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    mio_bridge_if #(.N_SLAVES(4), .DATA_W(32), .ADDR_W(32)) bus ();
    mio_bridge #(
        .N_SLAVES(4), .DATA_W(32), .ADDR_W(32), .SEL_HI(31), .SEL_LO(28),
        .WAIT_CYCLES(16'h3300), .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.s_rdata   = '0;
        bus.s_ack     = 4'b1111;
        cyc(2);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_ready", bus.mio_ready, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_sel", bus.s_sel, 0);
        chk("rst_we", bus.s_we, 0);
        chk("rst_addr", bus.s_addr, 0);
        chk("rst_wdata", bus.s_wdata, 0);
        reset = 1'b1;
        cyc(1);
        // slave 0 read, no wait states
        bus.s_rdata[31:0] = 32'h1234_5678;
        bus.cpu_addr = 32'h0000_0010;
        bus.cpu_req  = 1'b1;
        cyc(1);
        chk("t1_sel", bus.s_sel, 4'b0001);
        chk("t1_noready", bus.mio_ready, 0);
        chk("t1_addr", bus.s_addr, 32'h0000_0010);
        cyc(1);
        chk("t1_ready", bus.mio_ready, 1);
        chk("t1_rdata", bus.cpu_rdata, 32'h1234_5678);
        chk("t1_err", bus.err, 0);
        chk("t1_selclr", bus.s_sel, 0);
        bus.cpu_req = 1'b0;
        cyc(1);
        chk("t1_pulse", bus.mio_ready, 0);
        chk("t1_hold", bus.cpu_rdata, 32'h1234_5678);
        // slave 2 write, three wait states
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h2000_0004;
        bus.cpu_wdata = 32'hA5A5_A5A5;
        bus.cpu_req   = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_sel%0d", i), bus.s_sel, 4'b0100);
            chk($sformatf("t2_we%0d", i), bus.s_we, 1);
            chk($sformatf("t2_noready%0d", i), bus.mio_ready, 0);
            cyc(1);
        end
        chk("t2_ready", bus.mio_ready, 1);
        chk("t2_rdata", bus.cpu_rdata, 32'h1234_5678);
        chk("t2_selclr", bus.s_sel, 0);
        chk("t2_weclr", bus.s_we, 0);
        chk("t2_addr", bus.s_addr, 32'h2000_0004);
        chk("t2_wdata", bus.s_wdata, 32'hA5A5_A5A5);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        cyc(1);
        // decode miss
        bus.cpu_addr = 32'h7000_0000;
        bus.cpu_req  = 1'b1;
        cyc(1);
        chk("t3_ready", bus.mio_ready, 1);
        chk("t3_sel", bus.s_sel, 0);
        chk("t3_rdata", bus.cpu_rdata, 0);
        chk("t3_err", bus.err, 1);
        bus.cpu_req = 1'b0;
        cyc(1);
        chk("t3_pulse", bus.mio_ready, 0);
        chk("t3_errhold", bus.err, 1);
        // slave 1 read with ack stalled
        bus.s_ack = 4'b1101;
        bus.s_rdata[63:32] = 32'hCAFE_0001;
        bus.cpu_addr = 32'h1000_0000;
        bus.cpu_req  = 1'b1;
        cyc(1);
        chk("t4_errclr", bus.err, 0);
        chk("t4_sel", bus.s_sel, 4'b0010);
`ifdef MIO_TIMEOUT_EN
        cyc(3);
        chk("t4_to_wait", bus.mio_ready, 0);
        cyc(1);
        chk("t4_to_ready", bus.mio_ready, 1);
        chk("t4_to_err", bus.err, 1);
        chk("t4_to_rdata", bus.cpu_rdata, 0);
        bus.s_ack = 4'b1111;
`else
        cyc(10);
        chk("t4_stall_ready", bus.mio_ready, 0);
        chk("t4_stall_sel", bus.s_sel, 4'b0010);
        bus.s_ack = 4'b1111;
        cyc(1);
        chk("t4_ready", bus.mio_ready, 1);
        chk("t4_rdata", bus.cpu_rdata, 32'hCAFE_0001);
        chk("t4_err", bus.err, 0);
`endif
        bus.cpu_req = 1'b0;
        cyc(1);
        // reset asserted mid-access to slave 3
        bus.s_rdata[127:96] = 32'hDEAD_BEEF;
        bus.cpu_addr = 32'h3000_0000;
        bus.cpu_req  = 1'b1;
        cyc(2);
        chk("t5_sel_pre", bus.s_sel, 4'b1000);
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("t5_sel", bus.s_sel, 0);
        chk("t5_addr", bus.s_addr, 0);
        chk("t5_rdata", bus.cpu_rdata, 0);
        chk("t5_err", bus.err, 0);
        cyc(3);
        chk("t5_noready", bus.mio_ready, 0);
        reset = 1'b1;
        cyc(1);
        chk("t5_idle", bus.mio_ready, 0);
        bus.s_rdata[31:0] = 32'h0BAD_F00D;
        bus.cpu_addr = 32'h0000_0020;
        bus.cpu_req  = 1'b1;
        cyc(2);
        chk("t5_ready", bus.mio_ready, 1);
        chk("t5_rdata2", bus.cpu_rdata, 32'h0BAD_F00D);
        bus.cpu_req = 1'b0;
        cyc(1);
        // back-to-back requests with cpu_req held high
        bus.s_rdata[31:0] = 32'h1111_1111;
        bus.cpu_addr = 32'h0000_0100;
        bus.cpu_req  = 1'b1;
        cyc(1);
        chk("t6_sel_a", bus.s_sel, 4'b0001);
        chk("t6_addr_a", bus.s_addr, 32'h0000_0100);
        bus.cpu_addr = 32'h0000_0200;
        cyc(1);
        chk("t6_ready_a", bus.mio_ready, 1);
        chk("t6_rdata_a", bus.cpu_rdata, 32'h1111_1111);
        chk("t6_addr_hold", bus.s_addr, 32'h0000_0100);
        bus.s_rdata[31:0] = 32'h2222_2222;
        cyc(1);
        chk("t6_gap_ready", bus.mio_ready, 0);
        chk("t6_gap_sel", bus.s_sel, 0);
        cyc(1);
        chk("t6_sel_b", bus.s_sel, 4'b0001);
        chk("t6_addr_b", bus.s_addr, 32'h0000_0200);
        chk("t6_noready_b", bus.mio_ready, 0);
        cyc(1);
        chk("t6_ready_b", bus.mio_ready, 1);
        chk("t6_rdata_b", bus.cpu_rdata, 32'h2222_2222);
        bus.cpu_req = 1'b0;
        cyc(1);
        chk("t6_pulse_b", bus.mio_ready, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
